// File: rtl/tt_um_uart_tx.sv
// UART transmitter (8 data bits, optional even parity, 1 stop bit) wrapped in the
// TinyTapeout user-module pinout. A tx_valid/tx_ready handshake loads one byte per frame.
module tt_um_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned      CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_next;
    logic [7:0]       r_shift;
    logic             r_txd;
    logic             w_txd_next;
    logic             r_done;
    logic             w_done_next;
    logic             w_tx_valid;
    logic             w_tx_ready;
    logic             w_handshake;
    logic             w_bit_end;
    logic             w_unused;

    assign w_tx_valid  = uio_in[0];
    assign w_tx_ready  = (r_state == S_IDLE);
    assign w_handshake = w_tx_valid && w_tx_ready;
    assign w_bit_end   = (r_cnt == CNT_LAST);
    assign w_unused    = &{1'b0, ena, uio_in[7:1]};

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_txd     <= w_txd_next;
            r_done    <= w_done_next;
            if (w_handshake) begin
                r_shift <= ui_in;
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_next   = r_state;
        w_bit_idx_next = r_bit_idx;
        w_cnt_next     = w_bit_end ? '0 : r_cnt + CNT_W'(1);
        unique case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (w_tx_valid) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next   = S_DATA;
                    w_bit_idx_next = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // txd is registered from the next state so the line level lines up with the state.
    always_comb begin
        w_txd_next  = 1'b1;
        w_done_next = (r_state == S_STOP) && w_bit_end;
        unique case (w_state_next)
            S_IDLE:   w_txd_next = 1'b1;
            S_START:  w_txd_next = 1'b0;
            S_DATA:   w_txd_next = r_shift[w_bit_idx_next];
            S_PARITY: w_txd_next = ^r_shift;
            S_STOP:   w_txd_next = 1'b1;
            default:  w_txd_next = 1'b1;
        endcase

        uo_out  = {5'b0, r_done, ~w_tx_ready, r_txd};
        uio_out = {6'b0, w_tx_ready, 1'b0};
        uio_oe  = 8'b1111_1110;
    end

endmodule

// File: tb/tb_tt_um_uart_tx.sv
// Scoreboard bench for tt_um_uart_tx: instance 0 without parity, instance 1 with parity,
// both at 4 clocks per bit; a negedge monitor checks every frame cycle against queued bytes.
module tb_tt_um_uart_tx;

    localparam int CPB = 4;

    typedef struct {
        int         inst;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in   [2];
    logic [7:0] uio_in  [2];
    logic [7:0] uo_out  [2];
    logic [7:0] uio_out [2];
    logic [7:0] uio_oe  [2];

    int n_checks = 0;
    int n_fail   = 0;

    exp_t        exp_q[$];
    exp_t        mon_e;
    bit          in_frame    [2];
    int          cyc         [2];
    int          len         [2];
    int          idle_run    [2];
    int          last_gap    [2];
    int          frames_done [2];
    logic [10:0] frame       [2];

    tt_um_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (1'b1),
        .ui_in  (ui_in[0]),
        .uio_in (uio_in[0]),
        .uo_out (uo_out[0]),
        .uio_out(uio_out[0]),
        .uio_oe (uio_oe[0])
    );

    tt_um_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut_par (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (1'b1),
        .ui_in  (ui_in[1]),
        .uio_in (uio_in[1]),
        .uo_out (uo_out[1]),
        .uio_out(uio_out[1]),
        .uio_oe (uio_oe[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: pops one expected byte when busy rises, then checks every cycle of the frame.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check("static_pins",
                  {uio_oe[k], uo_out[k][7:3], uio_out[k][7:2], uio_out[k][0],
                   uo_out[k][1] ^ uio_out[k][1]},
                  {8'hFE, 5'd0, 6'd0, 1'b0, 1'b1});
            if (!rst_n) begin
                in_frame[k] = 1'b0;
                idle_run[k] = 0;
            end else if (!in_frame[k]) begin
                if (uo_out[k][1]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("sb_inst", k, mon_e.inst);
                        if (k == 1) begin
                            frame[k] = {1'b1, ^mon_e.data, mon_e.data, 1'b0};
                            len[k]   = 11 * CPB;
                        end else begin
                            frame[k] = {2'b11, mon_e.data, 1'b0};
                            len[k]   = 10 * CPB;
                        end
                        last_gap[k] = idle_run[k];
                        in_frame[k] = 1'b1;
                        check("frame_bit", {uo_out[k][2:0]}, {2'b01, frame[k][0]});
                        cyc[k] = 1;
                    end
                end else begin
                    idle_run[k]++;
                    check("idle_done", uo_out[k][2], 1'b0);
                end
            end else if (cyc[k] < len[k]) begin
                check("frame_bit", {uo_out[k][2:0]}, {2'b01, frame[k][cyc[k] / CPB]});
                cyc[k]++;
            end else begin
                check("frame_end", {uo_out[k][2:0]}, 3'b101);
                in_frame[k] = 1'b0;
                idle_run[k] = 1;
                frames_done[k]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [7:0] d);
        int waited;
        tick();
        ui_in[k]  = d;
        uio_in[k] = {7'h55, 1'b1};
        exp_q.push_back('{inst: k, data: d});
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!uo_out[k][1] && waited < 50);
        check("hs_latency", waited, 1);
        uio_in[k] = 8'h00;
    endtask

    task automatic wait_frames(input int k, input int target);
        int n;
        n = 0;
        while (frames_done[k] < target && n < 500) begin
            tick();
            n++;
        end
        check("frame_timeout", 32'(frames_done[k] >= target), 1);
    endtask

    initial begin
        int target;
        int n;
        for (int k = 0; k < 2; k++) begin
            ui_in[k]  = 8'h00;
            uio_in[k] = 8'h00;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_uo_out", uo_out[k], 8'h01);
            check("rst_uio_out", uio_out[k], 8'h02);
        end
        #20 rst_n = 1'b1;

        // Plain frame, no parity.
        target = frames_done[0] + 1;
        send(0, 8'hA5);
        wait_frames(0, target);

        // Mid-frame valid pulse and ui_in change must be ignored.
        target = frames_done[0] + 1;
        send(0, 8'h3C);
        repeat (10) tick();
        ui_in[0]  = 8'hC3;
        uio_in[0] = 8'h01;
        repeat (3) tick();
        uio_in[0] = 8'h00;
        ui_in[0]  = 8'h99;
        wait_frames(0, target);
        repeat (5) tick();

        // Back-to-back with tx_valid held high.
        target = frames_done[0] + 2;
        tick();
        ui_in[0]  = 8'h55;
        uio_in[0] = 8'h01;
        exp_q.push_back('{inst: 0, data: 8'h55});
        exp_q.push_back('{inst: 0, data: 8'hFF});
        n = 0;
        do begin
            tick();
            n++;
        end while (!uo_out[0][1] && n < 50);
        ui_in[0] = 8'hFF;
        n = 0;
        while (!uo_out[0][2] && n < 100) begin
            tick();
            n++;
        end
        check("b2b_done_seen", uo_out[0][2], 1'b1);
        tick();
        check("b2b_second_hs", uo_out[0][1], 1'b1);
        uio_in[0] = 8'h00;
        wait_frames(0, target);
        check("b2b_gap", last_gap[0], 1);

        // Even parity: 0x07 -> 1, 0x03 -> 0.
        target = frames_done[1] + 1;
        send(1, 8'h07);
        wait_frames(1, target);
        target = frames_done[1] + 1;
        send(1, 8'h03);
        wait_frames(1, target);

        // Asynchronous abort during data bit 3, then a clean frame.
        send(0, 8'h42);
        repeat (17) @(posedge clk);
        #1;
        check("pre_abort_txd", uo_out[0][0], 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("abort_uo_out", uo_out[0], 8'h01);
        check("abort_uio_out", uio_out[0], 8'h02);
        #4 rst_n = 1'b1;
        target = frames_done[0] + 1;
        send(0, 8'h81);
        wait_frames(0, target);

        repeat (5) tick();
        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
